// File: rtl/hv_adc_multi_avg.sv
// hv_adc_multi_avg: multi-channel ADC sample averager for the HV domain.
// Each channel synchronises its asynchronous ready strobe, accumulates the
// captured samples and reports a block or sliding average of depth
// 2^sel with optional round-half-up. Output is registered one edge after
// the history/sum update.
module hv_adc_multi_avg #(
  parameter int CH_NUM   = 2,
  parameter int ADC_DW   = 10,
  parameter int MAX_LOG2 = 3,
  parameter int ROUND    = 0,
  parameter int SEL_W    = $clog2(MAX_LOG2 + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [CH_NUM-1:0]                i_adc_rdy,
  input  logic [CH_NUM-1:0][ADC_DW-1:0]    i_adc_data,
  input  logic [CH_NUM-1:0]                i_ch_en,
  input  logic                             i_mode,
  input  logic [SEL_W-1:0]                 i_avg_sel,
  output logic [CH_NUM-1:0][ADC_DW-1:0]    o_ch_data,
  output logic [CH_NUM-1:0]                o_ch_vld
);

  localparam int HN = 1 << MAX_LOG2;
  localparam int SW = ADC_DW + MAX_LOG2;
  localparam int CW = MAX_LOG2 + 1;

  // Average of a running sum: floor, or round-half-up with saturation.
  function automatic logic [ADC_DW-1:0] avg_f(input logic [SW-1:0] s,
                                              input logic [SEL_W-1:0] sh);
    logic [SW:0] t;
    t = {1'b0, s};
    if (ROUND != 0 && sh != '0) t = t + ((SW+1)'(1) << (sh - SEL_W'(1)));
    t = t >> sh;
    if (ROUND != 0 && t > (SW+1)'({ADC_DW{1'b1}})) return {ADC_DW{1'b1}};
    return t[ADC_DW-1:0];
  endfunction

  logic [CH_NUM-1:0]             s1_q, s2_q, s3_q;
  logic [CH_NUM-1:0]             strobe;
  logic                          mode_q;
  logic [SEL_W-1:0]              sel_q;
  logic [SEL_W-1:0]              sel_clamp;
  logic                          flush;
  logic [CW-1:0]                 n_val;
  logic [MAX_LOG2-1:0]           last_idx;

  logic [ADC_DW-1:0]             hist_q  [CH_NUM][HN];
  logic [SW-1:0]                 sum_q   [CH_NUM];
  logic [CW-1:0]                 cnt_q   [CH_NUM];
  logic [CH_NUM-1:0]             pend_q;
  logic [ADC_DW-1:0]             pavg_q  [CH_NUM];
  logic [CH_NUM-1:0][ADC_DW-1:0] data_q;
  logic [CH_NUM-1:0]             vld_q;

  logic [SW-1:0]                 sum_d   [CH_NUM];
  logic [CW-1:0]                 cnt_d   [CH_NUM];
  logic [CH_NUM-1:0]             emit_d;
  logic [ADC_DW-1:0]             avg_d   [CH_NUM];

  // Depth selects above MAX_LOG2 silently saturate; compare the clamped
  // value so an out-of-range select does not flush every cycle.
  assign sel_clamp = (int'(i_avg_sel) > MAX_LOG2) ? SEL_W'(MAX_LOG2) : i_avg_sel;
  assign flush     = (i_mode != mode_q) || (sel_clamp != sel_q);
  assign n_val     = CW'(1) << sel_q;
  assign last_idx  = MAX_LOG2'(n_val - CW'(1));
  assign strobe    = s2_q & ~s3_q;

  assign o_ch_data = data_q;
  assign o_ch_vld  = vld_q;

  // Next sum/count per channel for a strobe, and whether it completes an average.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (mode_q) begin
        sum_d[c] = sum_q[c] + SW'(i_adc_data[c]) - SW'(hist_q[c][last_idx]);
        cnt_d[c] = (cnt_q[c] == n_val) ? cnt_q[c] : cnt_q[c] + CW'(1);
      end else begin
        sum_d[c] = sum_q[c] + SW'(i_adc_data[c]);
        cnt_d[c] = cnt_q[c] + CW'(1);
      end
      emit_d[c] = (cnt_d[c] == n_val);
      avg_d[c]  = avg_f(sum_d[c], sel_q);
    end
  end

  // Synchronisers, config latch, per-channel accumulation and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      mode_q <= 1'b0;
      sel_q  <= '0;
      pend_q <= '0;
      data_q <= '0;
      vld_q  <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        sum_q[c]  <= '0;
        cnt_q[c]  <= '0;
        pavg_q[c] <= '0;
        for (int k = 0; k < HN; k++) hist_q[c][k] <= '0;
      end
    end else begin
      s1_q   <= i_adc_rdy;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      mode_q <= i_mode;
      sel_q  <= sel_clamp;
      vld_q  <= pend_q;
      pend_q <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        if (pend_q[c]) data_q[c] <= pavg_q[c];
        if (flush || !i_ch_en[c]) begin
          sum_q[c] <= '0;
          cnt_q[c] <= '0;
          for (int k = 0; k < HN; k++) hist_q[c][k] <= '0;
        end else if (strobe[c]) begin
          hist_q[c][0] <= i_adc_data[c];
          for (int k = 1; k < HN; k++) hist_q[c][k] <= hist_q[c][k-1];
          // Block mode restarts the sum on the edge that completes a block.
          if (!mode_q && emit_d[c]) begin
            sum_q[c] <= '0;
            cnt_q[c] <= '0;
          end else begin
            sum_q[c] <= sum_d[c];
            cnt_q[c] <= cnt_d[c];
          end
          pend_q[c] <= emit_d[c];
          pavg_q[c] <= avg_d[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_hv_adc_multi_avg.sv
// Directed bench for hv_adc_multi_avg: a floor instance and a rounding
// instance share the same stimulus; a negedge monitor logs output pulses.
module tb_hv_adc_multi_avg;

  logic             clk;
  logic             rst;
  logic [1:0]       rdy;
  logic [1:0][9:0]  adc_data;
  logic [1:0]       ch_en;
  logic             mode;
  logic [1:0]       avg_sel;
  logic [1:0][9:0]  data0, data_r;
  logic [1:0]       vld0, vld_r;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int send_cyc = 0;
  int vcyc0 = -1;
  int vcyc1 = -1;
  int obs0[$];
  int obs1[$];
  int obsr0[$];

  hv_adc_multi_avg #(.CH_NUM(2), .ADC_DW(10), .MAX_LOG2(3), .ROUND(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_adc_rdy(rdy), .i_adc_data(adc_data),
    .i_ch_en(ch_en), .i_mode(mode), .i_avg_sel(avg_sel),
    .o_ch_data(data0), .o_ch_vld(vld0));

  hv_adc_multi_avg #(.CH_NUM(2), .ADC_DW(10), .MAX_LOG2(3), .ROUND(1)) dut_r (
    .i_clk(clk), .i_rst(rst), .i_adc_rdy(rdy), .i_adc_data(adc_data),
    .i_ch_en(ch_en), .i_mode(mode), .i_avg_sel(avg_sel),
    .o_ch_data(data_r), .o_ch_vld(vld_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (vld0[0] === 1'b1) begin obs0.push_back(int'(data0[0])); vcyc0 = cyc; end
    if (vld0[1] === 1'b1) begin obs1.push_back(int'(data0[1])); vcyc1 = cyc; end
    if (vld_r[0] === 1'b1) obsr0.push_back(int'(data_r[0]));
  end

  task automatic clear_obs();
    obs0.delete(); obs1.delete(); obsr0.delete();
    vcyc0 = -1; vcyc1 = -1;
  endtask

  task automatic set_cfg(input logic m, input logic [1:0] s);
    @(posedge clk); #1;
    mode = m; avg_sel = s;
    repeat (3) @(posedge clk);
  endtask

  task automatic send(input logic [1:0] mask, input int d0, input int d1);
    @(posedge clk); #1;
    if (mask[0]) adc_data[0] = 10'(d0);
    if (mask[1]) adc_data[1] = 10'(d1);
    rdy = rdy | mask;
    send_cyc = cyc;
    repeat (4) @(posedge clk); #1;
    rdy = rdy & ~mask;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = '0; adc_data = '0; ch_en = 2'b11; mode = 1'b0; avg_sel = '0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (data0 !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", data0); end
    n_cmp++; if (vld0 !== 2'b00) begin n_err++; $display("FAIL rst_vld: got %b want 00", vld0); end
    n_cmp++; if (data_r !== '0) begin n_err++; $display("FAIL rst_data_r: got %h want 0", data_r); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_block_floor();
    set_cfg(1'b0, 2'd2);
    clear_obs();
    send(2'b01, 100, 0); send(2'b01, 101, 0); send(2'b01, 102, 0); send(2'b01, 103, 0);
    n_cmp++; if (obs0.size() != 1) begin n_err++; $display("FAIL blk_cnt: got %0d pulses want 1", obs0.size()); end
    n_cmp++; if ((obs0.size() > 0 ? obs0[0] : -1) != 101) begin n_err++; $display("FAIL blk_avg: got %0d want 101", (obs0.size() > 0 ? obs0[0] : -1)); end
    n_cmp++; if (vcyc0 != send_cyc + 4) begin n_err++; $display("FAIL blk_lat: got cycle %0d want %0d", vcyc0, send_cyc + 4); end
    n_cmp++; if ((obsr0.size() > 0 ? obsr0[0] : -1) != 102) begin n_err++; $display("FAIL blk_round: got %0d want 102", (obsr0.size() > 0 ? obsr0[0] : -1)); end
    n_cmp++; if (obs1.size() != 0 || data0[1] !== 10'd0) begin n_err++; $display("FAIL blk_ch1: got %0d pulses data %0d want 0/0", obs1.size(), data0[1]); end
  endtask

  task automatic test_sliding();
    set_cfg(1'b1, 2'd2);
    clear_obs();
    send(2'b01, 4, 0); send(2'b01, 8, 0); send(2'b01, 12, 0);
    n_cmp++; if (obs0.size() != 0) begin n_err++; $display("FAIL sld_fill: got %0d pulses want 0", obs0.size()); end
    send(2'b01, 16, 0); send(2'b01, 20, 0); send(2'b01, 24, 0);
    n_cmp++; if (obs0.size() != 3) begin n_err++; $display("FAIL sld_cnt: got %0d pulses want 3", obs0.size()); end
    n_cmp++; if ((obs0.size() > 0 ? obs0[0] : -1) != 10) begin n_err++; $display("FAIL sld_1: got %0d want 10", (obs0.size() > 0 ? obs0[0] : -1)); end
    n_cmp++; if ((obs0.size() > 1 ? obs0[1] : -1) != 14) begin n_err++; $display("FAIL sld_2: got %0d want 14", (obs0.size() > 1 ? obs0[1] : -1)); end
    n_cmp++; if ((obs0.size() > 2 ? obs0[2] : -1) != 18) begin n_err++; $display("FAIL sld_3: got %0d want 18", (obs0.size() > 2 ? obs0[2] : -1)); end
  endtask

  task automatic test_round_sat();
    set_cfg(1'b0, 2'd1);
    clear_obs();
    send(2'b01, 3, 0); send(2'b01, 4, 0);
    n_cmp++; if ((obs0.size() > 0 ? obs0[0] : -1) != 3) begin n_err++; $display("FAIL rnd_floor: got %0d want 3", (obs0.size() > 0 ? obs0[0] : -1)); end
    n_cmp++; if ((obsr0.size() > 0 ? obsr0[0] : -1) != 4) begin n_err++; $display("FAIL rnd_half: got %0d want 4", (obsr0.size() > 0 ? obsr0[0] : -1)); end
    send(2'b01, 1023, 0); send(2'b01, 1023, 0);
    n_cmp++; if ((obs0.size() > 1 ? obs0[1] : -1) != 1023) begin n_err++; $display("FAIL sat_floor: got %0d want 1023", (obs0.size() > 1 ? obs0[1] : -1)); end
    n_cmp++; if ((obsr0.size() > 1 ? obsr0[1] : -1) != 1023) begin n_err++; $display("FAIL sat_round: got %0d want 1023", (obsr0.size() > 1 ? obsr0[1] : -1)); end
  endtask

  task automatic test_flush();
    set_cfg(1'b0, 2'd2);
    clear_obs();
    send(2'b01, 10, 0); send(2'b01, 20, 0);
    set_cfg(1'b0, 2'd1);
    n_cmp++; if (obs0.size() != 0) begin n_err++; $display("FAIL flush_vld: got %0d pulses want 0", obs0.size()); end
    send(2'b01, 50, 0); send(2'b01, 52, 0);
    n_cmp++; if (obs0.size() != 1) begin n_err++; $display("FAIL flush_cnt: got %0d pulses want 1", obs0.size()); end
    n_cmp++; if ((obs0.size() > 0 ? obs0[0] : -1) != 51) begin n_err++; $display("FAIL flush_avg: got %0d want 51", (obs0.size() > 0 ? obs0[0] : -1)); end
  endtask

  task automatic test_multi_enable();
    set_cfg(1'b0, 2'd0);
    clear_obs();
    send(2'b11, 7, 900);
    n_cmp++; if ((obs0.size() > 0 ? obs0[0] : -1) != 7) begin n_err++; $display("FAIL multi_ch0: got %0d want 7", (obs0.size() > 0 ? obs0[0] : -1)); end
    n_cmp++; if ((obs1.size() > 0 ? obs1[0] : -1) != 900) begin n_err++; $display("FAIL multi_ch1: got %0d want 900", (obs1.size() > 0 ? obs1[0] : -1)); end
    n_cmp++; if (vcyc0 != vcyc1 || vcyc0 < 0) begin n_err++; $display("FAIL multi_same: got cycles %0d/%0d want equal", vcyc0, vcyc1); end
    // Ready held high for 20 cycles yields a single sample.
    @(posedge clk); #1;
    adc_data[0] = 10'd33; rdy[0] = 1'b1;
    repeat (20) @(posedge clk); #1;
    rdy[0] = 1'b0;
    repeat (4) @(posedge clk);
    n_cmp++; if (obs0.size() != 2) begin n_err++; $display("FAIL held_cnt: got %0d pulses want 2", obs0.size()); end
    n_cmp++; if (data0[0] !== 10'd33) begin n_err++; $display("FAIL held_data: got %0d want 33", data0[0]); end
    @(posedge clk); #1;
    ch_en[1] = 1'b0;
    send(2'b11, 44, 55);
    n_cmp++; if (obs1.size() != 1 || data0[1] !== 10'd900) begin n_err++; $display("FAIL en_ch1: got %0d pulses data %0d want 1/900", obs1.size(), data0[1]); end
    n_cmp++; if (data0[0] !== 10'd44) begin n_err++; $display("FAIL en_ch0: got %0d want 44", data0[0]); end
    @(posedge clk); #1;
    ch_en[1] = 1'b1;
  endtask

  task automatic test_reset_mid();
    set_cfg(1'b0, 2'd2);
    clear_obs();
    send(2'b01, 77, 0); send(2'b01, 77, 0); send(2'b01, 77, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (data0[0] !== 10'd0 || vld0 !== 2'b00) begin n_err++; $display("FAIL rstmid_out: got %0d/%b want 0/00", data0[0], vld0); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    clear_obs();
    send(2'b01, 200, 0); send(2'b01, 200, 0); send(2'b01, 200, 0);
    n_cmp++; if (obs0.size() != 0) begin n_err++; $display("FAIL rstmid_early: got %0d pulses want 0", obs0.size()); end
    send(2'b01, 200, 0);
    n_cmp++; if (obs0.size() != 1 || (obs0.size() > 0 ? obs0[0] : -1) != 200) begin n_err++; $display("FAIL rstmid_avg: got %0d pulses value %0d want 1/200", obs0.size(), (obs0.size() > 0 ? obs0[0] : -1)); end
  endtask

  initial begin
    test_reset();
    test_block_floor();
    test_sliding();
    test_round_sat();
    test_flush();
    test_multi_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
